ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
//
// PURPOSE
// Time-multiplexed 4-digit seven-segment driver downstream of the game top's score digits.
// Consumes digitN_i/digitN_en_i, snapshots them once per scan cycle (no mid-scan tearing).
// Drives one active-low anode at a time with active-low hex-decoded segments.
// Sits between the game top and the board display pins; runs on the 25.175 MHz pixel clock.
//
// PARAMETERS
// CountWidth   15  dwell counter width; each digit is addressed for 2**CountWidth cycles
// GhostCycles  64  all-anodes-off cycles at the start of each dwell (anti-ghosting); must be < 2**CountWidth
//
// PORTS
// clk_i         in   1  pixel clock, 25.175 MHz
// rst_i         in   1  synchronous reset, active-high
// digit0_en_i   in   1  enable for digit 0 (least significant)
// digit0_i      in   4  hex value of digit 0
// digit1_en_i   in   1  enable for digit 1
// digit1_i      in   4  hex value of digit 1
// digit2_en_i   in   1  enable for digit 2
// digit2_i      in   4  hex value of digit 2
// digit3_en_i   in   1  enable for digit 3 (most significant)
// digit3_i      in   4  hex value of digit 3
// anode_o       out  4  active-low digit select; bit N = digit N
// segments_o    out  7  active-low segments {g,f,e,d,c,b,a}
//
// BEHAVIOUR
// - Reset (rst_i=1 at an edge): count_q=0, sel_q=0, shadow digits=0, shadow enables=0; anode_o=4'hF, segments_o=7'h7F.
// - count_q increments every cycle and wraps from all-ones to 0; at that wrap sel_q advances 0->1->2->3->0.
// - Snapshot: at the edge where count_q is all-ones and sel_q==3, all 8 inputs load into shadow regs.
//   No other load path; the first scan after reset is therefore dark (shadow enables=0).
// - Input changes between snapshots have no effect on the outputs.
// - Registered outputs, 1-cycle latency from (count_q, sel_q):
//   - anode_o = 4'hF when count_q < GhostCycles, or shadow_en[sel_q]==0, or digit sel_q is blanked;
//     otherwise ~(4'b0001 << sel_q).
//   - segments_o = decode(shadow digit sel_q) when that digit's anode is driven, else 7'h7F.
// - Decode {g..a}: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//   8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
// - At most one anode_o bit is low in any cycle.
// - Reset mid-scan: outputs return to reset values on the next cycle, the scan restarts at sel_q=0,
//   and the display stays dark until the next snapshot.
//
// CONFIGURATION
// SSD_LEADING_ZERO_BLANK_EN defined:
//   - digit3 blanked if its shadow value is 0;
//   - digit2 blanked if digit3 is blanked-or-disabled and digit2 is 0;
//   - digit1 blanked by the same rule against digit2;
//   - digit0 is never blanked.
// Not defined: no blanking; zero digits display "0" whenever enabled.
//
// TESTING (CountWidth=4, GhostCycles=2; scan cycle = 64 clocks)
// 1. rst_i=1 for 3 cycles, then digits 1,2,3,4 enabled -> anode_o=4'hF, segments_o=7'h7F through the whole first scan.
// 2. Digits 1,2,3,4 enabled, 2nd scan, sel_q=0 dwell:
//    - count 0-1 -> anode_o=4'hF;
//    - count 2-15 -> anode_o=4'b1110, segments_o=7'b1111001;
//    - sel_q=3 dwell -> anode_o=4'b0111, segments_o=7'b0011001.
// 3. Change digit0_i 1->9 during sel_q=1 -> digit 0 still shows 7'b1111001 until after the next 3->0 boundary, then 7'b0010000.
// 4. digit2_en_i=0, all others enabled -> anode_o never equals 4'b1011 across 4 scans.
// 5. Inputs 0,0,0,7 (digit3..0), all enabled:
//    - macro defined -> only anode_o=4'b1110 with segments_o=7'b1111000 ever drives;
//    - undefined -> digits 3..1 show 7'b1000000.
//    - Inputs 0000 with macro defined -> digit0 shows 7'b1000000, digits 3..1 dark.
// 6. Assert rst_i at count_q=9, sel_q=2 -> next cycle anode_o=4'hF, segments_o=7'h7F; after release sel_q=0, count_q=0, display dark for one scan.

Source files
------------

// File: rtl/ssd_scan_if.sv
// Digit inputs and display pin outputs of the seven-segment scan driver.
// master = score source (drives digits), slave = scan driver (drives pins).
interface ssd_scan_if;
  logic       digit0_en_i;
  logic [3:0] digit0_i;
  logic       digit1_en_i;
  logic [3:0] digit1_i;
  logic       digit2_en_i;
  logic [3:0] digit2_i;
  logic       digit3_en_i;
  logic [3:0] digit3_i;
  logic [3:0] anode_o;
  logic [6:0] segments_o;

  modport master (
    output digit0_en_i, digit0_i, digit1_en_i, digit1_i,
           digit2_en_i, digit2_i, digit3_en_i, digit3_i,
    input  anode_o, segments_o
  );

  modport slave (
    input  digit0_en_i, digit0_i, digit1_en_i, digit1_i,
           digit2_en_i, digit2_i, digit3_en_i, digit3_i,
    output anode_o, segments_o
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with once-per-scan input snapshot.
// Optional leading-zero blanking: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
  parameter int CountWidth  = 15,
  parameter int GhostCycles = 64
) (
  input logic        clk_i,
  input logic        rst_i,
  ssd_scan_if.slave  bus
);

  localparam logic [CountWidth-1:0] GhostLim = CountWidth'(GhostCycles);

  logic [CountWidth-1:0] count_q;
  logic [1:0]            sel_q;
  logic [3:0][3:0]       shadow_dig_q;
  logic [3:0]            shadow_en_q;
  logic [3:0]            anode_q;
  logic [6:0]            segments_q;

  logic [3:0][3:0] digit_in;
  logic [3:0]      en_in;
  logic [3:0]      blank;
  logic            wrap;
  logic            drive;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign digit_in = {bus.digit3_i, bus.digit2_i, bus.digit1_i, bus.digit0_i};
  assign en_in    = {bus.digit3_en_i, bus.digit2_en_i, bus.digit1_en_i, bus.digit0_en_i};
  assign wrap     = &count_q;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A zero stays blank only while every more significant digit is blank or disabled.
  always_comb begin
    blank    = '0;
    blank[3] = (shadow_dig_q[3] == 4'h0);
    blank[2] = (blank[3] || !shadow_en_q[3]) && (shadow_dig_q[2] == 4'h0);
    blank[1] = (blank[2] || !shadow_en_q[2]) && (shadow_dig_q[1] == 4'h0);
  end
`else
  assign blank = '0;
`endif

  // Ghost window at the start of each dwell lets the previous digit's pin discharge.
  assign drive = (count_q >= GhostLim) && shadow_en_q[sel_q] && !blank[sel_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q      <= '0;
      sel_q        <= 2'd0;
      shadow_dig_q <= '0;
      shadow_en_q  <= '0;
      anode_q      <= 4'hF;
      segments_q   <= 7'h7F;
    end else begin
      count_q <= count_q + 1'b1;
      if (wrap) begin
        sel_q <= sel_q + 2'd1;
      end
      // Snapshot only on the 3->0 boundary so a scan never mixes old and new digits.
      if (wrap && sel_q == 2'd3) begin
        shadow_dig_q <= digit_in;
        shadow_en_q  <= en_in;
      end
      anode_q    <= drive ? ~(4'b0001 << sel_q) : 4'hF;
      segments_q <= drive ? hex_to_seg(shadow_dig_q[sel_q]) : 7'h7F;
    end
  end

  assign bus.anode_o    = anode_q;
  assign bus.segments_o = segments_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (CountWidth=4, GhostCycles=2, 64-clock scan).
// Honors SSD_LEADING_ZERO_BLANK_EN in its reference model when defined.
module tb_ssd_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0][3:0] dig = '0;
  logic [3:0]      en  = '0;

  ssd_scan_if bus ();

  assign bus.digit0_i    = dig[0];
  assign bus.digit1_i    = dig[1];
  assign bus.digit2_i    = dig[2];
  assign bus.digit3_i    = dig[3];
  assign bus.digit0_en_i = en[0];
  assign bus.digit1_en_i = en[1];
  assign bus.digit2_en_i = en[2];
  assign bus.digit3_en_i = en[3];

  ssd_scan_driver #(.CountWidth(4), .GhostCycles(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time k counts clocks since reset; the scan is pure arithmetic on k.
  int              k = 0;
  int              last_k = 0;
  logic [3:0][3:0] sh_d = '0;
  logic [3:0]      sh_en = '0;
  logic [6:0]      seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [3:0]      en;
    logic [3:0][3:0] an;
    logic [3:0][6:0] sg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_blank(input int s);
    logic [3:0] b;
    logic       lead;
    b = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      b[i] = lead && (sh_d[i] == 4'h0);
      lead = b[i] || !sh_en[i];
    end
`else
    lead = 1'b0;
    b = {3'b000, lead};
`endif
    return b[s];
  endfunction

  task automatic model_out(input int kk, output logic [3:0] ea, output logic [6:0] es);
    int s;
    int c;
    s  = (kk / 16) % 4;
    c  = kk % 16;
    ea = 4'hF;
    es = 7'h7F;
    if (c >= 2 && sh_en[s] && !is_blank(s)) begin
      ea[s] = 1'b0;
      es    = seg_tab[sh_d[s]];
    end
  endtask

  task automatic tick();
    logic [3:0] ea;
    logic [6:0] es;
    int         kn;
    if (rst) begin
      ea    = 4'hF;
      es    = 7'h7F;
      sh_d  = '0;
      sh_en = '0;
      kn    = 0;
    end else begin
      model_out(k, ea, es);
      if (k % 64 == 63) begin
        sh_d  = dig;
        sh_en = en;
      end
      kn = k + 1;
    end
    @(posedge clk);
    #1;
    last_k = k;
    k      = kn;
    chk("anode_model", 32'(bus.anode_o), 32'(ea));
    chk("segments_model", 32'(bus.segments_o), 32'(es));
    chk("one_anode_max", 32'($countones(~bus.anode_o) <= 1), 32'd1);
  endtask

  task automatic align_scan();
    for (int i = 0; i < 64 && (k % 64) != 0; i++) tick();
    chk("align_scan", 32'(k % 64), 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    int   dark, hits, other, zeros, lit;
    int   s, c;

    vecs[0].d  = {4'hF, 4'hE, 4'hD, 4'hC};  vecs[0].en = 4'hF;
    vecs[0].an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    vecs[0].sg = {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110};
    vecs[1].d  = {4'h8, 4'hA, 4'hB, 4'h5};  vecs[1].en = 4'hF;
    vecs[1].an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    vecs[1].sg = {7'b0000000, 7'b0001000, 7'b0000011, 7'b0010010};
    vecs[2].d  = {4'h3, 4'h2, 4'h7, 4'h6};  vecs[2].en = 4'b0101;
    vecs[2].an = {4'hF, 4'b1011, 4'hF, 4'b1110};
    vecs[2].sg = {7'h7F, 7'b0100100, 7'h7F, 7'b0000010};
    vecs[3].d  = {4'h9, 4'h9, 4'h9, 4'h9};  vecs[3].en = 4'h0;
    vecs[3].an = {4'hF, 4'hF, 4'hF, 4'hF};
    vecs[3].sg = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Reset, then first scan is dark even with digits enabled.
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_anode", 32'(bus.anode_o), 32'hF);
    chk("reset_segments", 32'(bus.segments_o), 32'h7F);
    rst = 1'b0;
    dig = {4'h4, 4'h3, 4'h2, 4'h1};
    en  = 4'hF;
    dark = 0;
    repeat (64) begin
      tick();
      if (bus.anode_o == 4'hF && bus.segments_o == 7'h7F) dark++;
    end
    chk("first_scan_dark", 32'(dark), 32'd64);

    // Second scan: ghost window then digit 0 and digit 3 values.
    repeat (64) begin
      tick();
      s = (last_k / 16) % 4;
      c = last_k % 16;
      if (c < 2) chk("ghost_dark", 32'(bus.anode_o), 32'hF);
      else if (s == 0) begin
        chk("sel0_anode", 32'(bus.anode_o), 32'b1110);
        chk("sel0_seg", 32'(bus.segments_o), 32'b1111001);
      end else if (s == 3) begin
        chk("sel3_anode", 32'(bus.anode_o), 32'b0111);
        chk("sel3_seg", 32'(bus.segments_o), 32'b0011001);
      end
    end

    // Mid-scan input change is invisible until after the next 3->0 boundary.
    repeat (16) tick();
    dig[0] = 4'h9;
    repeat (48) begin
      tick();
      if (bus.anode_o == 4'b1110) chk("d0_not_torn", 32'(bus.segments_o), 32'b1111001);
    end
    repeat (16) begin
      tick();
      if (last_k % 16 >= 2) chk("d0_updated", 32'(bus.segments_o), 32'b0010000);
    end
    repeat (48) tick();

    // Disabled digit 2 never selected.
    en[2] = 1'b0;
    repeat (64) tick();
    hits = 0;
    lit  = 0;
    repeat (256) begin
      tick();
      if (bus.anode_o == 4'b1011) hits++;
      if (bus.anode_o == 4'b0111) lit++;
    end
    chk("digit2_never_on", 32'(hits), 32'd0);
    chk("digit3_still_on", 32'(lit), 32'd56);

    // Leading zeros: 0,0,0,7 then 0,0,0,0.
    dig = {4'h0, 4'h0, 4'h0, 4'h7};
    en  = 4'hF;
    repeat (64) tick();
    hits = 0; other = 0; zeros = 0;
    repeat (64) begin
      tick();
      if (bus.anode_o == 4'b1110 && bus.segments_o == 7'b1111000) hits++;
      else if (bus.anode_o != 4'hF) begin
        other++;
        if (bus.segments_o == 7'b1000000) zeros++;
      end
    end
    chk("lz_digit0_seven", 32'(hits), 32'd14);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    chk("lz_others_blank", 32'(other), 32'd0);
`else
    chk("lz_zeros_shown", 32'(zeros), 32'd42);
`endif
    dig = '0;
    repeat (64) tick();
    hits = 0; other = 0;
    repeat (64) begin
      tick();
      if (bus.anode_o == 4'b1110 && bus.segments_o == 7'b1000000) hits++;
      else if (bus.anode_o != 4'hF) other++;
    end
    chk("all_zero_digit0", 32'(hits), 32'd14);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    chk("all_zero_upper_dark", 32'(other), 32'd0);
`else
    chk("all_zero_upper_lit", 32'(other), 32'd42);
`endif

    // Reset mid-scan at count 9, sel 2.
    dig = {4'h4, 4'h3, 4'h2, 4'h1};
    repeat (64) tick();
    for (int i = 0; i < 64 && (k % 64) != 41; i++) tick();
    chk("reach_sel2_cnt9", 32'(k % 64), 32'd41);
    rst = 1'b1;
    tick();
    chk("midreset_anode", 32'(bus.anode_o), 32'hF);
    chk("midreset_seg", 32'(bus.segments_o), 32'h7F);
    rst = 1'b0;
    dark = 0;
    repeat (64) begin
      tick();
      if (bus.anode_o == 4'hF) dark++;
    end
    chk("post_reset_dark", 32'(dark), 32'd64);
    lit = 0;
    repeat (64) begin
      tick();
      if (bus.anode_o != 4'hF) lit++;
    end
    chk("post_reset_relit", 32'(lit), 32'd56);

    // Table-driven dwell checks at count 8 of each digit.
    foreach (vecs[v]) begin
      dig = vecs[v].d;
      en  = vecs[v].en;
      align_scan();
      repeat (64) tick();
      repeat (64) begin
        tick();
        s = (last_k / 16) % 4;
        if (last_k % 16 == 8) begin
          chk($sformatf("vec%0d_anode_sel%0d", v, s), 32'(bus.anode_o), 32'(vecs[v].an[s]));
          chk($sformatf("vec%0d_seg_sel%0d", v, s), 32'(bus.segments_o), 32'(vecs[v].sg[s]));
        end
      end
    end

    // Random inputs and occasional resets against the model.
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) begin
        dig[$urandom_range(0, 3)] = 4'($urandom);
        en = 4'($urandom);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
